sm_regdump_tx: RTL and testbench
================================

Name: sm_regdump_tx

Overview:
Debug-port reader for the CPU core. On a start pulse it walks the CPU debug register port (regAddr/regData) from FIRST_REG to LAST_REG. For each register it captures the value and sends it over a UART transmit line as a 5-byte record, giving a host a serial dump of the architectural state without a JTAG path. It sits beside the core at the top level:
- Its regAddr output drives the core's debug address input.
- The core's debug data output drives its regData input.

Parameters:
BAUD_DIV, 434, clock cycles per UART bit (minimum 2); 434 gives 115200 baud at 50 MHz.
FIRST_REG, 0, first debug address dumped. Address 0 returns the PC on the core's debug port.
LAST_REG, 31, last debug address dumped. FIRST_REG <= LAST_REG <= 31 is required and is checked at elaboration.

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high.
start  in  1  single-cycle request to begin a dump; sampled only while busy=0.
regAddr  out  5  debug register address to the core.
regData  in  32  debug register data from the core; combinational function of regAddr.
tx  out  1  UART serial output: 8N1, LSB first, idle high.
busy  out  1  high from the cycle after an accepted start until the cycle the final stop bit ends.
done  out  1  one-cycle pulse when a dump completes.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: tx=1, busy=0, done=0, regAddr=FIRST_REG, state=IDLE. All counters are zero.
- Reset mid-dump aborts immediately: tx=1 on the next edge, no partial-byte completion, no done pulse.
- States: IDLE, LOAD, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - start=1 -> regAddr<=FIRST_REG, go to LOAD.
- LOAD (exactly 1 cycle, tx=1, busy=1):
  - snapshot<=regData for the current regAddr.
  - byte_idx<=0, go to START.
  - Later changes on regData do not affect the record being sent.
- Record byte order, byte_idx 0..4:
  - 0: {3'b000, regAddr}
  - 1: snapshot[31:24]
  - 2: snapshot[23:16]
  - 3: snapshot[15:8]
  - 4: snapshot[7:0]
- Bit timing:
  - The baud counter runs 0..BAUD_DIV-1, so each bit is held for exactly BAUD_DIV cycles.
  - The counter clears on every state entry.
- START: tx=0 for one bit time, then go to DATA with bit_idx=0.
- DATA:
  - tx=byte[bit_idx] for one bit time each.
  - After bit_idx=7, go to STOP.
- STOP: tx=1 for one bit time, then:
  - byte_idx<4: byte_idx+1, go to START. Bytes are back to back with no extra idle.
  - byte_idx=4 and regAddr<LAST_REG: regAddr+1, go to LOAD.
  - byte_idx=4 and regAddr=LAST_REG: go to IDLE with done=1 for that one cycle, busy=0. regAddr holds LAST_REG.
- Timing:
  - Cycles per register = 1 + 50*BAUD_DIV.
  - Full dump = N*(1+50*BAUD_DIV), where N = LAST_REG-FIRST_REG+1.
  - The first start bit appears on tx in the second cycle after start is sampled.
- start while busy=1 is ignored (no queuing).
- start in the same cycle as done (first IDLE cycle) is accepted, and a new dump begins.
- regAddr changes only at register boundaries. It is stable throughout a record, including LOAD.

Test Plan:
1. BAUD_DIV=4, FIRST_REG=LAST_REG=5, core r5=32'h12345678, pulse start:
   - tx idle high, then 5 frames with bytes 0x05, 0x12, 0x34, 0x56, 0x78, each LSB first, 4 cycles per bit.
   - done pulses exactly 1+200 cycles after LOAD.
2. BAUD_DIV=4, full 0..31 range, rf[i]=i*32'h01010101, PC=32'h00000010:
   - Decoded stream is 32 records with addresses 0..31 in order.
   - Record 0 data = 0x00000010.
   - Total busy time = 32*201 cycles.
   - done pulses once.
3. Snapshot: change regData one cycle after LOAD -> transmitted data equals the value sampled in LOAD.
4. start pulsed repeatedly mid-dump -> no effect on tx or regAddr. start in the done cycle -> second dump starts, with the first start bit 2 cycles later.
5. rst asserted during the DATA bit of byte 2 -> tx=1, busy=0, regAddr=FIRST_REG next cycle, and no done pulse. A subsequent start gives a clean full dump.
6. BAUD_DIV=2 (minimum) -> bit widths are exactly 2 cycles and the byte sequence is still correct.

Source files
------------

// File: rtl/sm_regdump_tx.sv
// Debug-port register dumper: walks regAddr from FIRST_REG to LAST_REG and sends each
// register as a 5-byte 8N1 UART record {addr, data[31:24], [23:16], [15:8], [7:0]}.
module sm_regdump_tx #(
   parameter int BAUD_DIV  = 434,
   parameter int FIRST_REG = 0,
   parameter int LAST_REG  = 31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [4:0]  regAddr,
   input  logic [31:0] regData,
   output logic        tx,
   output logic        busy,
   output logic        done
);
   localparam int               CNT_W      = $clog2(BAUD_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BAUD_DIV - 1);
   localparam logic [4:0]       FIRST_ADDR = 5'(FIRST_REG);
   localparam logic [4:0]       LAST_ADDR  = 5'(LAST_REG);

   if (BAUD_DIV < 2 || FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_bad_params
      $error("sm_regdump_tx: illegal BAUD_DIV/FIRST_REG/LAST_REG");
   end

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [2:0]       byte_idx_q, byte_idx_d;
   logic [4:0]       addr_q, addr_d;
   logic [31:0]      snap_q, snap_d;
   logic             tx_q, tx_d;
   logic             done_q, done_d;
   logic             bit_end;
   logic [7:0]       cur_byte;
   logic [7:0]       rec_byte [8];

   // Record bytes come from registered state; entries past byte 4 are never selected.
   assign rec_byte[0] = {3'b000, addr_q};
   for (genvar gi = 1; gi < 8; gi++) begin : g_rec
      if (gi <= 4) begin : g_data
         assign rec_byte[gi] = snap_q[39 - 8*gi -: 8];
      end else begin : g_pad
         assign rec_byte[gi] = 8'hFF;
      end
   end

   assign cur_byte = rec_byte[byte_idx_q];
   assign bit_end  = (cnt_q == CNT_LAST);

   always_comb begin
      state_d    = state_q;
      cnt_d      = '0;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      addr_d     = addr_q;
      snap_d     = snap_q;
      done_d     = 1'b0;
      tx_d       = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d  = FIRST_ADDR;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            snap_d     = regData;
            byte_idx_d = '0;
            state_d    = S_START;
         end
         S_START: begin
            if (bit_end) begin
               bit_idx_d = '0;
               state_d   = S_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_idx_q == 3'd7) state_d = S_STOP;
               else                   bit_idx_d = bit_idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (byte_idx_q != 3'd4) begin
                  byte_idx_d = byte_idx_q + 3'd1;
                  state_d    = S_START;
               end else if (addr_q < LAST_ADDR) begin
                  addr_d  = addr_q + 5'd1;
                  state_d = S_LOAD;
               end else begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // tx is registered from the next state so the line level is glitch-free and
      // lines up exactly with the state it belongs to.
      if (state_d == S_START)     tx_d = 1'b0;
      else if (state_d == S_DATA) tx_d = cur_byte[bit_idx_d];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         byte_idx_q <= '0;
         addr_q     <= FIRST_ADDR;
         snap_q     <= '0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         addr_q     <= addr_d;
         snap_q     <= snap_d;
         tx_q       <= tx_d;
         done_q     <= done_d;
      end
   end

   assign regAddr = addr_q;
   assign tx      = tx_q;
   assign busy    = (state_q != S_IDLE);
   assign done    = done_q;

endmodule

// File: tb/tb_sm_regdump_tx.sv
// Bench for sm_regdump_tx: three instances (single register, full range, minimum baud)
// against a core register-file model; tx is checked cycle by cycle and decoded.
module tb_sm_regdump_tx;
   localparam int B0 = 4, F0 = 5, L0 = 5;
   localparam int B1 = 4, F1 = 0, L1 = 31;
   localparam int B2 = 2, F2 = 3, L2 = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_v   [3];
   logic        corrupt_v [3];
   logic        tx_v      [3];
   logic        busy_v    [3];
   logic        done_v    [3];
   logic [4:0]  addr_v    [3];
   logic [31:0] data_v    [3];
   logic [31:0] rf        [32];

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   // Core debug port: combinational lookup, optionally disturbed to probe the snapshot.
   always_comb begin
      for (int k = 0; k < 3; k++)
         data_v[k] = corrupt_v[k] ? ~rf[addr_v[k]] : rf[addr_v[k]];
   end

   sm_regdump_tx #(.BAUD_DIV(B0), .FIRST_REG(F0), .LAST_REG(L0)) dut0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .regAddr(addr_v[0]), .regData(data_v[0]),
      .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
   sm_regdump_tx #(.BAUD_DIV(B1), .FIRST_REG(F1), .LAST_REG(L1)) dut1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .regAddr(addr_v[1]), .regData(data_v[1]),
      .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
   sm_regdump_tx #(.BAUD_DIV(B2), .FIRST_REG(F2), .LAST_REG(L2)) dut2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .regAddr(addr_v[2]), .regData(data_v[2]),
      .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

   function automatic int bd(input int k);
      return (k == 0) ? B0 : (k == 1) ? B1 : B2;
   endfunction
   function automatic int fr(input int k);
      return (k == 0) ? F0 : (k == 1) ? F1 : F2;
   endfunction
   function automatic int lr(input int k);
      return (k == 0) ? L0 : (k == 1) ? L1 : L2;
   endfunction

   task automatic fill_random();
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
   endtask

   task automatic pulse_start(input int k);
      @(negedge clk);
      start_v[k] = 1'b1;
      @(negedge clk);
      start_v[k] = 1'b0;
   endtask

   // Called in cycle 1 (the LOAD cycle) of a dump; follows it to the done cycle.
   task automatic observe_dump(input int k, input bit mid_starts, input bit glitch,
                               input bit restart, input string tag);
      int b, n, rlen, t, idx;
      int busy_bad, done_bad, addr_bad, wave_bad;
      bit          exp_w [$];
      logic        obs_tx [$];
      logic [4:0]  exp_a [$];
      logic [31:0] exp_d [$];
      logic [4:0]  a;
      logic [39:0] rec, got;
      logic [7:0]  v;
      b = bd(k); n = lr(k) - fr(k) + 1; rlen = 1 + 50*b; t = n*rlen;
      busy_bad = 0; done_bad = 0; addr_bad = 0; wave_bad = 0;
      for (int r = 0; r < n; r++) begin
         a   = 5'(fr(k) + r);
         rec = {3'b000, a, rf[a]};
         exp_a.push_back(a);
         exp_d.push_back(rf[a]);
         exp_w.push_back(1'b1);
         for (int by = 0; by < 5; by++) begin
            v = rec[39 - 8*by -: 8];
            repeat (b) exp_w.push_back(1'b0);
            for (int i = 0; i < 8; i++) repeat (b) exp_w.push_back(v[i]);
            repeat (b) exp_w.push_back(1'b1);
         end
      end
      for (int j = 1; j <= t; j++) begin
         if (j > 1) @(negedge clk);
         corrupt_v[k] = glitch && (((j - 1) % rlen) != 0);
         start_v[k]   = mid_starts ? ($urandom_range(0, 3) == 0) : 1'b0;
         obs_tx.push_back(tx_v[k]);
         if (busy_v[k] !== 1'b1) busy_bad++;
         if (done_v[k] !== 1'b0) done_bad++;
         if (addr_v[k] !== exp_a[(j - 1) / rlen]) addr_bad++;
      end
      @(negedge clk);
      corrupt_v[k] = 1'b0;
      start_v[k]   = restart;
      checks++;
      if (done_v[k] !== 1'b1 || busy_v[k] !== 1'b0 || addr_v[k] !== 5'(lr(k)) || tx_v[k] !== 1'b1)
         $display("FAIL %s done_cycle: done=%b busy=%b addr=%0d tx=%b, required done=1 busy=0 addr=%0d tx=1",
                  tag, done_v[k], busy_v[k], addr_v[k], tx_v[k], lr(k));
      else passes++;
      checks++;
      if (busy_bad !== 0) $display("FAIL %s busy_span: %0d cycles low, required 0", tag, busy_bad);
      else passes++;
      checks++;
      if (done_bad !== 0) $display("FAIL %s early_done: %0d cycles high, required 0", tag, done_bad);
      else passes++;
      checks++;
      if (addr_bad !== 0) $display("FAIL %s regaddr_stable: %0d bad cycles, required 0", tag, addr_bad);
      else passes++;
      for (int i = 0; i < t; i++) if (obs_tx[i] !== exp_w[i]) wave_bad++;
      checks++;
      if (wave_bad !== 0) $display("FAIL %s tx_waveform: %0d bad cycles, required 0", tag, wave_bad);
      else passes++;
      for (int r = 0; r < n; r++) begin
         got = '0;
         for (int by = 0; by < 5; by++)
            for (int i = 0; i < 8; i++) begin
               idx = r*rlen + 1 + by*10*b + b*(1 + i) + b/2;
               got[39 - 8*by - 7 + i] = obs_tx[idx];
            end
         checks++;
         if (got[39:32] !== {3'b000, exp_a[r]})
            $display("FAIL %s rec%0d_addr: got %02h, required %02h", tag, r, got[39:32], {3'b000, exp_a[r]});
         else passes++;
         checks++;
         if (got[31:0] !== exp_d[r])
            $display("FAIL %s rec%0d_data: got %08h, required %08h", tag, r, got[31:0], exp_d[r]);
         else passes++;
      end
      $display("dump %s: %0d records, %0d cycles busy, wave_errors=%0d", tag, n, t, wave_bad);
      @(negedge clk);
      start_v[k] = 1'b0;
      if (!restart) begin
         checks++;
         if (done_v[k] !== 1'b0 || busy_v[k] !== 1'b0)
            $display("FAIL %s after_done: done=%b busy=%b, required 0 0", tag, done_v[k], busy_v[k]);
         else passes++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (tx_v[k] !== 1'b1 || busy_v[k] !== 1'b0 || done_v[k] !== 1'b0 || addr_v[k] !== 5'(fr(k)))
            $display("FAIL reset_state%0d: tx=%b busy=%b done=%b addr=%0d, required 1 0 0 %0d",
                     k, tx_v[k], busy_v[k], done_v[k], addr_v[k], fr(k));
         else passes++;
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (busy_v[1] !== 1'b0 || tx_v[1] !== 1'b1)
         $display("FAIL idle_after_reset: busy=%b tx=%b, required 0 1", busy_v[1], tx_v[1]);
      else passes++;
      $display("reset: all instances idle");
   endtask

   task automatic test_single_record();
      fill_random();
      rf[5] = 32'h12345678;
      checks++;
      if (tx_v[0] !== 1'b1) $display("FAIL single_idle_tx: tx=%b, required 1", tx_v[0]);
      else passes++;
      pulse_start(0);
      observe_dump(0, 1'b0, 1'b0, 1'b0, "single_r5");
   endtask

   task automatic test_full_dump();
      for (int i = 0; i < 32; i++) rf[i] = i * 32'h01010101;
      rf[0] = 32'h00000010;
      pulse_start(1);
      observe_dump(1, 1'b0, 1'b0, 1'b0, "full_0_31");
   endtask

   task automatic test_snapshot();
      fill_random();
      pulse_start(0);
      observe_dump(0, 1'b0, 1'b1, 1'b0, "snapshot_single");
      fill_random();
      pulse_start(2);
      observe_dump(2, 1'b0, 1'b1, 1'b0, "snapshot_multi");
   endtask

   task automatic test_back_to_back();
      fill_random();
      pulse_start(1);
      observe_dump(1, 1'b1, 1'b0, 1'b1, "busy_start_ignored");
      observe_dump(1, 1'b0, 1'b0, 1'b0, "restart_in_done");
   endtask

   task automatic test_reset_mid_dump();
      int b, bad_done, bad_idle;
      b = B1;
      fill_random();
      pulse_start(1);
      repeat (3*(1 + 50*b) + 1 + 20*b + 3*b) @(negedge clk);
      checks++;
      if (busy_v[1] !== 1'b1 || addr_v[1] !== 5'd3)
         $display("FAIL pre_abort: busy=%b addr=%0d, required 1 3", busy_v[1], addr_v[1]);
      else passes++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (tx_v[1] !== 1'b1 || busy_v[1] !== 1'b0 || addr_v[1] !== 5'(F1) || done_v[1] !== 1'b0)
         $display("FAIL abort_state: tx=%b busy=%b addr=%0d done=%b, required 1 0 %0d 0",
                  tx_v[1], busy_v[1], addr_v[1], done_v[1], F1);
      else passes++;
      bad_done = 0; bad_idle = 0;
      repeat (60*b) begin
         @(negedge clk);
         if (done_v[1] !== 1'b0) bad_done++;
         if (tx_v[1] !== 1'b1 || busy_v[1] !== 1'b0) bad_idle++;
      end
      checks++;
      if (bad_done !== 0 || bad_idle !== 0)
         $display("FAIL abort_quiet: done_cycles=%0d active_cycles=%0d, required 0 0", bad_done, bad_idle);
      else passes++;
      $display("abort: reset mid-dump at reg 3 byte 2");
      pulse_start(1);
      observe_dump(1, 1'b0, 1'b0, 1'b0, "after_abort");
   endtask

   task automatic test_min_baud();
      fill_random();
      pulse_start(2);
      observe_dump(2, 1'b0, 1'b0, 1'b0, "min_baud");
   endtask

   initial begin
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         start_v[k]   = 1'b0;
         corrupt_v[k] = 1'b0;
      end
      for (int i = 0; i < 32; i++) rf[i] = '0;
      test_reset();
      test_single_record();
      test_full_dump();
      test_snapshot();
      test_back_to_back();
      test_reset_mid_dump();
      test_min_baud();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end
endmodule
